// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side operand selection.
//
// Captures decode-stage operands and control on each rising CLK, honouring
// FlushE (load a bubble) over StallE (hold). Forwarding from MEM/WB is then
// resolved combinationally on the registered data to produce the ALU
// operands, the store data and the destination register.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   StallE, FlushE    hold / bubble controls (flush wins)
//   RD1D, RD2D        register-file read data from decode
//   SignImmD          sign-extended immediate
//   RsD, RtD, RdD     register addresses
//   ALUControlD       ALU opcode
//   ALUSrcD, RegDstD  operand-B and destination selects
//   RegWriteD, MemtoRegD, MemWriteD  control pipelined to later stages
//   ForwardAE/BE      forwarding selects (00 reg, 01 ResultW, 10 ALUOutM, 11 reg)
//   ALUOutM, ResultW  forwarding sources
//   SrcAE, SrcBE      ALU operands
//   ALUControlE       ALU opcode
//   WriteDataE        forwarded rt data (store data)
//   WriteRegE         destination register
//   RsE, RtE          source registers for the hazard unit
//   RegWriteE, MemtoRegE, MemWriteE  registered control
//   ValidE            1 = real instruction, 0 = bubble
module id_ex_stage #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               StallE,
   input  logic               FlushE,
   input  logic [WIDTH-1:0]   RD1D,
   input  logic [WIDTH-1:0]   RD2D,
   input  logic [WIDTH-1:0]   SignImmD,
   input  logic [RADDR_W-1:0] RsD,
   input  logic [RADDR_W-1:0] RtD,
   input  logic [RADDR_W-1:0] RdD,
   input  logic [2:0]         ALUControlD,
   input  logic               ALUSrcD,
   input  logic               RegDstD,
   input  logic               RegWriteD,
   input  logic               MemtoRegD,
   input  logic               MemWriteD,
   input  logic [1:0]         ForwardAE,
   input  logic [1:0]         ForwardBE,
   input  logic [WIDTH-1:0]   ALUOutM,
   input  logic [WIDTH-1:0]   ResultW,
   output logic [WIDTH-1:0]   SrcAE,
   output logic [WIDTH-1:0]   SrcBE,
   output logic [2:0]         ALUControlE,
   output logic [WIDTH-1:0]   WriteDataE,
   output logic [RADDR_W-1:0] WriteRegE,
   output logic [RADDR_W-1:0] RsE,
   output logic [RADDR_W-1:0] RtE,
   output logic               RegWriteE,
   output logic               MemtoRegE,
   output logic               MemWriteE,
   output logic               ValidE
);

   logic [WIDTH-1:0]   rd1_q, rd1_d;
   logic [WIDTH-1:0]   rd2_q, rd2_d;
   logic [WIDTH-1:0]   imm_q, imm_d;
   logic [RADDR_W-1:0] rs_q, rs_d;
   logic [RADDR_W-1:0] rt_q, rt_d;
   logic [RADDR_W-1:0] rd_q, rd_d;
   logic [2:0]         aluctl_q, aluctl_d;
   logic               alusrc_q, alusrc_d;
   logic               regdst_q, regdst_d;
   logic               regwrite_q, regwrite_d;
   logic               memtoreg_q, memtoreg_d;
   logic               memwrite_q, memwrite_d;
   logic               valid_q, valid_d;

   logic [WIDTH-1:0]   fwd_a, fwd_b;

   always_comb begin
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
      imm_d      = imm_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      aluctl_d   = aluctl_q;
      alusrc_d   = alusrc_q;
      regdst_d   = regdst_q;
      regwrite_d = regwrite_q;
      memtoreg_d = memtoreg_q;
      memwrite_d = memwrite_q;
      valid_d    = valid_q;
      if (FlushE) begin
         // Bubble: every field cleared so it has no architectural side effect.
         rd1_d      = '0;
         rd2_d      = '0;
         imm_d      = '0;
         rs_d       = '0;
         rt_d       = '0;
         rd_d       = '0;
         aluctl_d   = '0;
         alusrc_d   = 1'b0;
         regdst_d   = 1'b0;
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         memwrite_d = 1'b0;
         valid_d    = 1'b0;
      end else if (!StallE) begin
         rd1_d      = RD1D;
         rd2_d      = RD2D;
         imm_d      = SignImmD;
         rs_d       = RsD;
         rt_d       = RtD;
         rd_d       = RdD;
         aluctl_d   = ALUControlD;
         alusrc_d   = ALUSrcD;
         regdst_d   = RegDstD;
         regwrite_d = RegWriteD;
         memtoreg_d = MemtoRegD;
         memwrite_d = MemWriteD;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd1_q      <= '0;
         rd2_q      <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         aluctl_q   <= '0;
         alusrc_q   <= 1'b0;
         regdst_q   <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memwrite_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         imm_q      <= imm_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         aluctl_q   <= aluctl_d;
         alusrc_q   <= alusrc_d;
         regdst_q   <= regdst_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         memwrite_q <= memwrite_d;
         valid_q    <= valid_d;
      end
   end

   // Forwarding uses the live MEM/WB values; code 11 falls back to the register.
   always_comb begin
      unique case (ForwardAE)
         2'b10:   fwd_a = ALUOutM;
         2'b01:   fwd_a = ResultW;
         default: fwd_a = rd1_q;
      endcase
      unique case (ForwardBE)
         2'b10:   fwd_b = ALUOutM;
         2'b01:   fwd_b = ResultW;
         default: fwd_b = rd2_q;
      endcase
   end

   assign SrcAE       = fwd_a;
   assign SrcBE       = alusrc_q ? imm_q : fwd_b;
   // Store data always takes the forwarded rt value, independent of ALUSrc.
   assign WriteDataE  = fwd_b;
   assign WriteRegE   = regdst_q ? rd_q : rt_q;
   assign ALUControlE = aluctl_q;
   assign RsE         = rs_q;
   assign RtE         = rt_q;
   assign RegWriteE   = regwrite_q;
   assign MemtoRegE   = memtoreg_q;
   assign MemWriteE   = memwrite_q;
   assign ValidE      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        StallE, FlushE;
   logic [31:0] RD1D, RD2D, SignImmD;
   logic [4:0]  RsD, RtD, RdD;
   logic [2:0]  ALUControlD;
   logic        ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUOutM, ResultW;
   logic [31:0] SrcAE, SrcBE, WriteDataE;
   logic [2:0]  ALUControlE;
   logic [4:0]  WriteRegE, RsE, RtE;
   logic        RegWriteE, MemtoRegE, MemWriteE, ValidE;

   int checks   = 0;
   int failures = 0;

   id_ex_stage #(.WIDTH(32), .RADDR_W(5)) dut (
      .CLK(CLK), .RST(RST), .StallE(StallE), .FlushE(FlushE),
      .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
      .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
      .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .RegWriteD(RegWriteD),
      .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUOutM(ALUOutM), .ResultW(ResultW),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
      .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .RsE(RsE), .RtE(RtE),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .ValidE(ValidE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; samples land 1ns after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [2:0] ctl, input logic alusrc,
                            input logic regdst, input logic regwr,
                            input logic memtoreg, input logic memwr);
      RD1D = rd1; RD2D = rd2; SignImmD = imm;
      RsD = rs; RtD = rt; RdD = rd; ALUControlD = ctl;
      ALUSrcD = alusrc; RegDstD = regdst; RegWriteD = regwr;
      MemtoRegD = memtoreg; MemWriteD = memwr;
   endtask

   initial begin
      RST = 1'b0; StallE = 1'b0; FlushE = 1'b0;
      ForwardAE = 2'b00; ForwardBE = 2'b00; ALUOutM = '0; ResultW = '0;
      set_instr(32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

      // Reset dominates clock edges with valid D inputs.
      tick();
      chk("reset_valid", {31'b0, ValidE}, 32'h0);
      chk("reset_srca", SrcAE, 32'h0);
      chk("reset_regwr", {31'b0, RegWriteE}, 32'h0);

      @(negedge CLK);
      RST = 1'b1;

      // Normal load
      set_instr(32'h5, 32'h3, 32'h0, 5'd1, 5'd2, 5'd7, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("load_srca", SrcAE, 32'h5);
      chk("load_srcb", SrcBE, 32'h3);
      chk("load_aluctl", {29'b0, ALUControlE}, 32'h4);
      chk("load_wreg", {27'b0, WriteRegE}, 32'd7);
      chk("load_valid", {31'b0, ValidE}, 32'h1);
      chk("load_rse", {27'b0, RsE}, 32'd1);
      chk("load_rte", {27'b0, RtE}, 32'd2);

      // Forwarding is combinational: no edge between steps.
      ALUOutM = 32'h0000AAAA; ResultW = 32'h00005555;
      ForwardAE = 2'b10; #1;
      chk("fwd_a_mem", SrcAE, 32'h0000AAAA);
      ForwardBE = 2'b01; #1;
      chk("fwd_b_wb", SrcBE, 32'h00005555);
      chk("fwd_b_wdata", WriteDataE, 32'h00005555);
      ForwardAE = 2'b11; #1;
      chk("fwd_a_11", SrcAE, 32'h5);
      ForwardAE = 2'b01; #1;
      chk("fwd_a_wb", SrcAE, 32'h00005555);
      ForwardAE = 2'b00; ForwardBE = 2'b00;

      // Immediate operand with forwarded store data
      set_instr(32'h9, 32'h10, 32'hFFFFFFFC, 5'd4, 5'd5, 5'd6, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("imm_wdata_reg", WriteDataE, 32'h10);
      ForwardBE = 2'b10; ALUOutM = 32'h20; #1;
      chk("imm_srcb", SrcBE, 32'hFFFFFFFC);
      chk("imm_wdata_fwd", WriteDataE, 32'h20);
      chk("imm_wreg_rt", {27'b0, WriteRegE}, 32'd5);
      ForwardBE = 2'b00;

      // Stall holds instruction A
      set_instr(32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd9, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      StallE = 1'b1;
      set_instr(32'hDEAD, 32'hBEEF, 32'h1, 5'd8, 5'd8, 5'd8, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_instr(32'hCAFE, 32'hF00D, 32'h2, 5'd9, 5'd9, 5'd9, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("stall_srca", SrcAE, 32'h11);
      chk("stall_srcb", SrcBE, 32'h22);
      chk("stall_aluctl", {29'b0, ALUControlE}, 32'h1);
      chk("stall_wreg", {27'b0, WriteRegE}, 32'd4);
      chk("stall_memwr", {31'b0, MemWriteE}, 32'h1);
      chk("stall_memtoreg", {31'b0, MemtoRegE}, 32'h1);
      chk("stall_valid", {31'b0, ValidE}, 32'h1);

      // Flush beats stall
      FlushE = 1'b1;
      tick();
      chk("flush_valid", {31'b0, ValidE}, 32'h0);
      chk("flush_regwr", {31'b0, RegWriteE}, 32'h0);
      chk("flush_memwr", {31'b0, MemWriteE}, 32'h0);
      chk("flush_aluctl", {29'b0, ALUControlE}, 32'h0);
      chk("flush_srca", SrcAE, 32'h0);
      StallE = 1'b0; FlushE = 1'b0;

      // Back-to-back instructions
      for (int i = 0; i < 4; i++) begin
         set_instr(32'h100 * i + 32'h1, 32'h0, 32'h0, 5'd0, 5'd0, 5'(10 + i),
                   3'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
         chk($sformatf("b2b_srca_%0d", i), SrcAE, 32'h100 * i + 32'h1);
         chk($sformatf("b2b_wreg_%0d", i), {27'b0, WriteRegE}, 32'(10 + i));
         chk($sformatf("b2b_aluctl_%0d", i), {29'b0, ALUControlE}, 32'(i));
      end

      // Asynchronous reset mid-cycle with nonzero state
      #2;
      RST = 1'b0;
      #1;
      chk("areset_valid", {31'b0, ValidE}, 32'h0);
      chk("areset_regwr", {31'b0, RegWriteE}, 32'h0);
      chk("areset_wreg", {27'b0, WriteRegE}, 32'h0);
      chk("areset_srca", SrcAE, 32'h0);
      chk("areset_aluctl", {29'b0, ALUControlE}, 32'h0);

      // First edge after release loads normally
      @(negedge CLK);
      RST = 1'b1;
      set_instr(32'h77, 32'h88, 32'h0, 5'd2, 5'd3, 5'd4, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("post_reset_valid", {31'b0, ValidE}, 32'h1);
      chk("post_reset_srca", SrcAE, 32'h77);
      chk("post_reset_wreg", {27'b0, WriteRegE}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
